mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a load and a store requester.
// IDLE grants a request, REQ waits for mem_ack (bounded by TIMEOUT), RESP emits the response pulse.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_gnt_o,
  output logic        ld_rvalid_o,
  output logic [31:0] ld_rdata_o,
  input  logic        st_req_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_wdata_i,
  output logic        st_gnt_o,
  output logic        st_done_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_st_q, prio_st_d;  // 1 = store wins a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        ld_gnt_q, ld_gnt_d;
  logic        st_gnt_q, st_gnt_d;
  logic        ld_rvalid_q, ld_rvalid_d;
  logic        st_done_q, st_done_d;
  logic [31:0] ld_rdata_q, ld_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        pick_ld;

  always_comb begin
    state_d     = state_q;
    prio_st_d   = prio_st_q;
    cnt_d       = cnt_q;
    ld_gnt_d    = 1'b0;
    st_gnt_d    = 1'b0;
    ld_rvalid_d = 1'b0;
    st_done_d   = 1'b0;
    err_d       = 1'b0;
    ld_rdata_d  = ld_rdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pick_ld     = ld_req_i && (!st_req_i || !prio_st_q);

    case (state_q)
      S_IDLE: begin
        if (!stall_i && (ld_req_i || st_req_i)) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          prio_st_d = pick_ld;
          mem_we_d  = !pick_ld;
          ld_gnt_d  = pick_ld;
          st_gnt_d  = !pick_ld;
          if (pick_ld) begin
            mem_addr_d = ld_addr_i;
          end else begin
            mem_addr_d  = st_addr_i;
            mem_wdata_d = st_wdata_i;
          end
        end
      end
      S_REQ: begin
        // An ack in the final allowed cycle still completes the transaction.
        if (mem_ack_i) begin
          state_d     = S_RESP;
          ld_rvalid_d = !mem_we_q;
          st_done_d   = mem_we_q;
          if (!mem_we_q) ld_rdata_d = mem_rdata_i;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      prio_st_q   <= 1'b0;
      cnt_q       <= '0;
      ld_gnt_q    <= 1'b0;
      st_gnt_q    <= 1'b0;
      ld_rvalid_q <= 1'b0;
      st_done_q   <= 1'b0;
      ld_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_st_q   <= prio_st_d;
      cnt_q       <= cnt_d;
      ld_gnt_q    <= ld_gnt_d;
      st_gnt_q    <= st_gnt_d;
      ld_rvalid_q <= ld_rvalid_d;
      st_done_q   <= st_done_d;
      ld_rdata_q  <= ld_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign ld_gnt_o    = ld_gnt_q;
  assign st_gnt_o    = st_gnt_q;
  assign ld_rvalid_o = ld_rvalid_q;
  assign st_done_o   = st_done_q;
  assign ld_rdata_o  = ld_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule
